// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: ALU opcode mnemonics and result-slot state.
// Opcode codes 8..15 are not assigned and pass through the arbiter untouched.
package Definitions;

  localparam int ARB_MAX_REQ = 8;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    SHL = 4'd5,
    SHR = 4'd6,
    NOP = 4'd7
  } op_mne;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle between the requesters, the arbiter, the external ALU and the result consumer.
// The slave modport is the arbiter's view; master is the surrounding system.
interface alu_arbiter_if
  import Definitions::*;
#(
  parameter int W    = 8,
  parameter int NREQ = 3
) ();

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] req_lock;
  logic [W-1:0]    req_a [NREQ];
  logic [W-1:0]    req_b [NREQ];
  op_mne           req_op [NREQ];

  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  op_mne           alu_op;
  logic [W-1:0]    alu_out;
  logic            alu_zero;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [W-1:0]    rsp_out;
  logic            rsp_zero;

  modport slave (
    input  req_valid, req_lock, req_a, req_b, req_op,
    input  alu_out, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_out, rsp_zero
  );

  modport master (
    output req_valid, req_lock, req_a, req_b, req_op,
    output alu_out, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_out, rsp_zero
  );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping at NREQ.
// i_ptr must stay below NREQ.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  always_comb begin
    logic [IDW-1:0] w_j;
    o_any = 1'b0;
    o_idx = '0;
    o_gnt = '0;
    w_j   = i_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_any && i_req[w_j]) begin
        o_any = 1'b1;
        o_idx = w_j;
      end
      w_j = (w_j == IDW'(NREQ - 1)) ? '0 : w_j + 1'b1;
    end
    if (o_any) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one external combinational ALU with a 1-deep result register.
// Build macro ALU_ARB_LOCK_EN enables burst lock via req_lock; otherwise req_lock is ignored.
module alu_arbiter
  import Definitions::*;
#(
  parameter int W    = 8,
  parameter int NREQ = 3
) (
  input logic          clk,
  input logic          reset_n,
  alu_arbiter_if.slave bus
);

  // state | meaning
  // EMPTY | result slot free; any pick may issue
  // FULL  | result held on rsp_*; a new issue needs rsp_ready in the same cycle

  localparam int IDW = $clog2(NREQ);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_rsp_id;
  logic [W-1:0]    r_rsp_out;
  logic            r_rsp_zero;

  logic            w_can_issue;
  logic            w_grant;
  logic            w_lock_hit;
  logic            w_sel_any;
  logic            w_rr_any;
  logic [IDW-1:0]  w_rr_idx;
  logic [IDW-1:0]  w_sel_idx;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [NREQ-1:0] w_rr_gnt;
  logic [NREQ-1:0] w_sel_gnt;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx),
    .o_any (w_rr_any)
  );

`ifdef ALU_ARB_LOCK_EN
  logic           r_have_last;
  logic [IDW-1:0] r_last;

  // A locked owner keeps the ALU ahead of the round-robin order until it drops lock or valid.
  assign w_lock_hit = r_have_last & bus.req_valid[r_last] & bus.req_lock[r_last];
  assign w_sel_any  = w_lock_hit | w_rr_any;
  assign w_sel_idx  = w_lock_hit ? r_last : w_rr_idx;
  assign w_sel_gnt  = w_lock_hit ? (NREQ'(1) << r_last) : w_rr_gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_have_last <= 1'b0;
      r_last      <= '0;
    end else if (w_grant) begin
      r_have_last <= 1'b1;
      r_last      <= w_sel_idx;
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = ^bus.req_lock;
  assign w_lock_hit    = 1'b0;
  assign w_sel_any     = w_rr_any;
  assign w_sel_idx     = w_rr_idx;
  assign w_sel_gnt     = w_rr_gnt;
`endif

  assign w_can_issue = (r_state == EMPTY) | bus.rsp_ready;
  // Grant is gated by reset_n so req_ready reads zero while reset is held.
  assign w_grant     = w_sel_any & w_can_issue & reset_n;
  assign w_ptr_nxt   = (w_rr_idx == IDW'(NREQ - 1)) ? '0 : w_rr_idx + 1'b1;

  assign bus.req_ready = w_grant ? w_sel_gnt : '0;
  assign bus.rsp_valid = (r_state == FULL);
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_out   = r_rsp_out;
  assign bus.rsp_zero  = r_rsp_zero;

  always_comb begin
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_op = NOP;
    if (w_sel_any) begin
      bus.alu_a  = bus.req_a[w_sel_idx];
      bus.alu_b  = bus.req_b[w_sel_idx];
      bus.alu_op = bus.req_op[w_sel_idx];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_grant) w_state_nxt = FULL;
      FULL:  if (bus.rsp_ready && !w_grant) w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_rsp_id   <= '0;
      r_rsp_out  <= '0;
      r_rsp_zero <= 1'b0;
    end else if (w_grant) begin
      r_rsp_id   <= w_sel_idx;
      r_rsp_out  <= bus.alu_out;
      r_rsp_zero <= bus.alu_zero;
      if (!w_lock_hit) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic against a cycle-level model.
// The bench also plays the external ALU.
module tb_alu_arbiter;
  import Definitions::*;

  localparam int W    = 8;
  localparam int NREQ = 3;

`ifdef ALU_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
  localparam logic [2:0] T6_EXP [5] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
`else
  localparam bit LOCK = 1'b0;
  localparam logic [2:0] T6_EXP [5] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   n_chk   = 0;
  int   n_err   = 0;

  bit         m_full;
  bit         m_have_last;
  int         m_ptr;
  int         m_last;
  int         m_id;
  logic [7:0] m_out;
  bit         m_zero;

  alu_arbiter_if #(.W(W), .NREQ(NREQ)) bus ();

  alu_arbiter #(.W(W), .NREQ(NREQ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input op_mne op);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      SHL:     return a << 1;
      SHR:     return a >> 1;
      NOP:     return 8'h00;
      default: return ~(a ^ b);
    endcase
  endfunction

  assign bus.alu_out  = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_zero = (bus.alu_out == 8'h00);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic [2:0] e);
    #1;
    chk(tag, bus.req_ready, e);
  endtask

  task automatic set_req(input int i, input op_mne op, input logic [7:0] a, input logic [7:0] b);
    bus.req_op[i] = op;
    bus.req_a[i]  = a;
    bus.req_b[i]  = b;
  endtask

  task automatic model_reset();
    m_full      = 1'b0;
    m_have_last = 1'b0;
    m_ptr       = 0;
    m_last      = 0;
    m_id        = 0;
    m_out       = 8'h00;
    m_zero      = 1'b0;
  endtask

  // Called just after a negedge with inputs applied; checks this cycle, then advances the model.
  task automatic cycle();
    bit         any;
    bit         lh;
    bit         can;
    int         g;
    logic [2:0] e_rdy;
    #1;
    can = !m_full || bus.rsp_ready;
    lh  = LOCK && m_have_last && bus.req_valid[m_last] && bus.req_lock[m_last];
    any = 1'b0;
    g   = 0;
    if (lh) begin
      any = 1'b1;
      g   = m_last;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (!any && bus.req_valid[j]) begin
          any = 1'b1;
          g   = j;
        end
      end
    end
    e_rdy = '0;
    if (any && can) e_rdy[g] = 1'b1;
    chk("req_ready", bus.req_ready, e_rdy);
    chk("alu_a", bus.alu_a, any ? bus.req_a[g] : 8'h00);
    chk("alu_b", bus.alu_b, any ? bus.req_b[g] : 8'h00);
    chk("alu_op", bus.alu_op, any ? bus.req_op[g] : NOP);
    chk("rsp_valid", bus.rsp_valid, m_full);
    if (m_full) begin
      chk("rsp_id", bus.rsp_id, m_id);
      chk("rsp_out", bus.rsp_out, m_out);
      chk("rsp_zero", bus.rsp_zero, m_zero);
    end
    @(posedge clk);
    if (any && can) begin
      m_full = 1'b1;
      m_id   = g;
      m_out  = alu_fn(bus.req_a[g], bus.req_b[g], bus.req_op[g]);
      m_zero = (m_out == 8'h00);
      if (!lh) m_ptr = (g + 1) % NREQ;
      m_last      = g;
      m_have_last = 1'b1;
    end else if (bus.rsp_ready) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ra;
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, NOP, 8'h00, 8'h00);
    model_reset();

    // Reset state with every requester asking
    #1 reset_n = 1'b0;
    bus.req_valid = 3'b111;
    @(negedge clk);
    #1;
    chk("rst_valid", bus.rsp_valid, 1'b0);
    chk("rst_id", bus.rsp_id, 0);
    chk("rst_out", bus.rsp_out, 8'h00);
    chk("rst_zero", bus.rsp_zero, 1'b0);
    chk("rst_ready", bus.req_ready, 3'b000);
    @(negedge clk);
    reset_n       = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;

    // Single ADD from requester 0
    set_req(0, ADD, 8'h05, 8'h03);
    bus.req_valid = 3'b001;
    chk_rdy("t2_rdy", 3'b001);
    cycle();
    bus.req_valid = '0;
    chk("t2_valid", bus.rsp_valid, 1'b1);
    chk("t2_id", bus.rsp_id, 0);
    chk("t2_out", bus.rsp_out, 8'h08);
    chk("t2_zero", bus.rsp_zero, 1'b0);

    // Zero result from requester 2; pointer wraps back to 0
    set_req(2, SUB, 8'h07, 8'h07);
    bus.req_valid = 3'b100;
    chk_rdy("t4_rdy", 3'b100);
    cycle();
    chk("t4_id", bus.rsp_id, 2);
    chk("t4_out", bus.rsp_out, 8'h00);
    chk("t4_zero", bus.rsp_zero, 1'b1);

    // All requesters valid every cycle
    set_req(0, ADD, 8'h01, 8'h02);
    set_req(1, XOR, 8'h0F, 8'hF0);
    set_req(2, SUB, 8'h09, 8'h04);
    bus.req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      chk_rdy("t3_rdy", 3'(1 << (i % 3)));
      cycle();
    end

    // Backpressure holds the slot, then drain and refill in one cycle
    bus.rsp_ready = 1'b0;
    bus.req_valid = 3'b010;
    for (int i = 0; i < 3; i++) begin
      chk_rdy("t5_blk_rdy", 3'b000);
      chk("t5_hold_id", bus.rsp_id, 2);
      chk("t5_hold_out", bus.rsp_out, 8'h05);
      cycle();
    end
    bus.rsp_ready = 1'b1;
    chk_rdy("t5_rdy", 3'b010);
    cycle();
    chk("t5_valid", bus.rsp_valid, 1'b1);
    chk("t5_id", bus.rsp_id, 1);
    chk("t5_out", bus.rsp_out, 8'hFF);
    bus.req_valid = '0;
    cycle();
    chk("t5_drained", bus.rsp_valid, 1'b0);

    // Reset while FULL with the pointer away from 0
    bus.req_valid = 3'b010;
    bus.rsp_ready = 1'b0;
    cycle();
    chk("t1_full", bus.rsp_valid, 1'b1);
    reset_n       = 1'b0;
    bus.req_valid = 3'b111;
    #1;
    chk("t1_valid", bus.rsp_valid, 1'b0);
    chk("t1_id", bus.rsp_id, 0);
    chk("t1_out", bus.rsp_out, 8'h00);
    chk("t1_ready", bus.req_ready, 3'b000);
    model_reset();
    @(negedge clk);
    reset_n       = 1'b1;
    bus.rsp_ready = 1'b1;
    chk_rdy("t1_first", 3'b001);
    cycle();

    // Burst lock on requester 1 (pure round-robin when the lock feature is off)
    bus.req_valid = 3'b111;
    for (int i = 0; i < 5; i++) begin
      bus.req_lock = (i < 3) ? 3'b010 : 3'b000;
      chk_rdy("t6_rdy", T6_EXP[i]);
      cycle();
    end
    bus.req_lock = '0;

    // Random traffic, including unassigned opcodes and frequent equal operands
    for (int n = 0; n < 400; n++) begin
      bus.req_valid = 3'($urandom_range(0, 7));
      bus.req_lock  = 3'($urandom_range(0, 7));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        ra = 8'($urandom);
        set_req(i, op_mne'(4'($urandom_range(0, 15))), ra,
                ($urandom_range(0, 2) == 0) ? ra : 8'($urandom));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
